// File: rtl/row_pkt_pkg.sv
// rtl/row_pkt_pkg.sv - shared row-packet constants, completion status codes and receiver FSM encoding
package row_pkt_pkg;

    localparam int AXIS_DATA_WIDTH  = 512;
    localparam int DATA_BEATS_DEF   = 16;
    localparam int REQ_ID_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_SHORT    = 2'd1,
        ST_LONG     = 2'd2,
        ST_MISMATCH = 2'd3
    } cpl_status_e;

    typedef enum logic [2:0] {
        S_HDR    = 3'd0,
        S_DATA   = 3'd1,
        S_FTR    = 3'd2,
        S_RESYNC = 3'd3,
        S_CPL    = 3'd4
    } rx_state_e;

endpackage

// File: rtl/axis_out_reg.sv
// rtl/axis_out_reg.sv - single-stage TDATA+TLAST output register with valid/ready flow control
module axis_out_reg #(
    parameter int W = 512
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tlast,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tlast,
    output logic         m_tvalid,
    input  logic         m_tready
);

    logic [W-1:0] tdata_q;
    logic         tlast_q;
    logic         tvalid_q;

    // Reload on the same edge the downstream consumes, so a full register never bubbles.
    assign s_tready = !tvalid_q || m_tready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else if (s_tready) begin
            tvalid_q <= s_tvalid;
            tlast_q  <= s_tvalid && s_tlast;
            if (s_tvalid) begin
                tdata_q <= s_tdata;
            end
        end
    end

    assign m_tdata  = tdata_q;
    assign m_tlast  = tlast_q;
    assign m_tvalid = tvalid_q;

endmodule

// File: rtl/row_pkt_receiver.sv
// rtl/row_pkt_receiver.sv - strips header/footer of row packets, forwards data, posts completions; stats under ROW_PKT_RX_STATS_EN
module row_pkt_receiver
    import row_pkt_pkg::*;
#(
    parameter int REQ_ID_WIDTH = REQ_ID_WIDTH_DEF,
    parameter int DATA_BEATS   = DATA_BEATS_DEF
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [AXIS_DATA_WIDTH-1:0] AXIS_RX_TDATA,
    input  logic                       AXIS_RX_TVALID,
    input  logic                       AXIS_RX_TLAST,
    output logic                       AXIS_RX_TREADY,
    output logic [AXIS_DATA_WIDTH-1:0] AXIS_TX_TDATA,
    output logic                       AXIS_TX_TVALID,
    output logic                       AXIS_TX_TLAST,
    input  logic                       AXIS_TX_TREADY,
    output logic [REQ_ID_WIDTH-1:0]    CPL_ID,
    output logic [1:0]                 CPL_STATUS,
    output logic                       CPL_VALID,
    input  logic                       CPL_READY,
    output logic [31:0]                PKT_COUNT,
    output logic [31:0]                ERR_COUNT
);

    localparam int CNT_W = $clog2(DATA_BEATS + 1);

    rx_state_e               state_q, state_d;
    logic [REQ_ID_WIDTH-1:0] hdr_id_q, hdr_id_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    cpl_status_e             status_q, status_d;

    logic rx_tready;
    logic rx_fire;
    logic out_s_tready;
    logic out_s_tvalid;
    logic out_s_tlast;
    logic last_data_beat;
    logic cpl_valid;
    logic cpl_fire;

    assign last_data_beat = (beat_cnt_q == CNT_W'(1));

    always_comb begin
        rx_tready = 1'b0;
        case (state_q)
            S_HDR, S_FTR, S_RESYNC: rx_tready = 1'b1;
            S_DATA:                 rx_tready = out_s_tready;
            default:                rx_tready = 1'b0;
        endcase
    end

    assign AXIS_RX_TREADY = rx_tready && resetn;
    assign rx_fire        = AXIS_RX_TVALID && AXIS_RX_TREADY;

    assign out_s_tvalid = (state_q == S_DATA) && rx_fire;
    assign out_s_tlast  = AXIS_RX_TLAST || last_data_beat;

    axis_out_reg #(
        .W (AXIS_DATA_WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .resetn   (resetn),
        .s_tdata  (AXIS_RX_TDATA),
        .s_tlast  (out_s_tlast),
        .s_tvalid (out_s_tvalid),
        .s_tready (out_s_tready),
        .m_tdata  (AXIS_TX_TDATA),
        .m_tlast  (AXIS_TX_TLAST),
        .m_tvalid (AXIS_TX_TVALID),
        .m_tready (AXIS_TX_TREADY)
    );

    // The completion waits for the output register to drain so it never overtakes its data.
    assign cpl_valid = (state_q == S_CPL) && !AXIS_TX_TVALID;
    assign cpl_fire  = cpl_valid && CPL_READY;

    always_comb begin
        state_d    = state_q;
        hdr_id_d   = hdr_id_q;
        beat_cnt_d = beat_cnt_q;
        status_d   = status_q;
        case (state_q)
            S_HDR: begin
                if (rx_fire) begin
                    hdr_id_d   = AXIS_RX_TDATA[REQ_ID_WIDTH-1:0];
                    beat_cnt_d = CNT_W'(DATA_BEATS);
                    if (AXIS_RX_TLAST) begin
                        status_d = ST_SHORT;
                        state_d  = S_CPL;
                    end else begin
                        state_d  = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    beat_cnt_d = beat_cnt_q - CNT_W'(1);
                    if (AXIS_RX_TLAST) begin
                        status_d = ST_SHORT;
                        state_d  = S_CPL;
                    end else if (last_data_beat) begin
                        state_d  = S_FTR;
                    end
                end
            end
            S_FTR: begin
                if (rx_fire) begin
                    if (!AXIS_RX_TLAST) begin
                        status_d = ST_LONG;
                        state_d  = S_RESYNC;
                    end else if (AXIS_RX_TDATA[REQ_ID_WIDTH-1:0] != hdr_id_q) begin
                        status_d = ST_MISMATCH;
                        state_d  = S_CPL;
                    end else begin
                        status_d = ST_OK;
                        state_d  = S_CPL;
                    end
                end
            end
            S_RESYNC: begin
                if (rx_fire && AXIS_RX_TLAST) begin
                    state_d = S_CPL;
                end
            end
            S_CPL: begin
                if (cpl_fire) begin
                    state_d = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_HDR;
            hdr_id_q   <= '0;
            beat_cnt_q <= '0;
            status_q   <= ST_OK;
        end else begin
            state_q    <= state_d;
            hdr_id_q   <= hdr_id_d;
            beat_cnt_q <= beat_cnt_d;
            status_q   <= status_d;
        end
    end

    assign CPL_VALID  = cpl_valid;
    assign CPL_ID     = hdr_id_q;
    assign CPL_STATUS = status_q;

`ifdef ROW_PKT_RX_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [31:0] err_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (cpl_fire) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (status_q != ST_OK) begin
                err_cnt_q <= err_cnt_q + 32'd1;
            end
        end
    end

    assign PKT_COUNT = pkt_cnt_q;
    assign ERR_COUNT = err_cnt_q;
`else
    assign PKT_COUNT = '0;
    assign ERR_COUNT = '0;
`endif

endmodule

// File: tb/tb_row_pkt_receiver.sv
// tb/tb_row_pkt_receiver.sv - scoreboard bench for row_pkt_receiver with a packet-level reference model
module tb_row_pkt_receiver;

    localparam int NBEATS = 16;

    typedef struct {
        logic [511:0] data;
        logic         last;
    } beat_t;

    typedef struct {
        logic [511:0] data;
        logic         last;
        int           pid;
    } tx_exp_t;

    typedef struct {
        logic [31:0] id;
        logic [1:0]  st;
        int          pid;
    } cpl_exp_t;

    logic         clk;
    logic         resetn;
    logic [511:0] AXIS_RX_TDATA;
    logic         AXIS_RX_TVALID;
    logic         AXIS_RX_TLAST;
    logic         AXIS_RX_TREADY;
    logic [511:0] AXIS_TX_TDATA;
    logic         AXIS_TX_TVALID;
    logic         AXIS_TX_TLAST;
    logic         AXIS_TX_TREADY;
    logic [31:0]  CPL_ID;
    logic [1:0]   CPL_STATUS;
    logic         CPL_VALID;
    logic         CPL_READY;
    logic [31:0]  PKT_COUNT;
    logic [31:0]  ERR_COUNT;

    row_pkt_receiver dut (
        .clk            (clk),
        .resetn         (resetn),
        .AXIS_RX_TDATA  (AXIS_RX_TDATA),
        .AXIS_RX_TVALID (AXIS_RX_TVALID),
        .AXIS_RX_TLAST  (AXIS_RX_TLAST),
        .AXIS_RX_TREADY (AXIS_RX_TREADY),
        .AXIS_TX_TDATA  (AXIS_TX_TDATA),
        .AXIS_TX_TVALID (AXIS_TX_TVALID),
        .AXIS_TX_TLAST  (AXIS_TX_TLAST),
        .AXIS_TX_TREADY (AXIS_TX_TREADY),
        .CPL_ID         (CPL_ID),
        .CPL_STATUS     (CPL_STATUS),
        .CPL_VALID      (CPL_VALID),
        .CPL_READY      (CPL_READY),
        .PKT_COUNT      (PKT_COUNT),
        .ERR_COUNT      (ERR_COUNT)
    );

    tx_exp_t  exp_tx[$];
    cpl_exp_t exp_cpl[$];
    int checks  = 0;
    int errors  = 0;
    int exp_pkt = 0;
    int exp_err = 0;
    int next_pid = 0;
    int tx_mode = 0;
    int cyc = 0;
    bit mon_en = 0;
    bit gap_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not seen (expected it)", name);
    endtask

    function automatic int cnt_exp(input int v);
`ifdef ROW_PKT_RX_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    // Packet builder: short_at=0 puts TLAST on the header, 1..NBEATS on that data beat, -1 none;
    // extras>0 means the footer lacks TLAST and that many trailing beats follow, the last with TLAST.
    function automatic void build(input logic [31:0] id, input logic [31:0] fid, input int short_at,
                                  input int extras, input bit seq, output beat_t b[$]);
        beat_t x;
        b.delete();
        x.data = rand512(); x.data[31:0] = id; x.last = (short_at == 0);
        b.push_back(x);
        if (short_at == 0) return;
        for (int n = 1; n <= NBEATS; n++) begin
            x.data = seq ? 512'(n) : rand512();
            x.last = (n == short_at);
            b.push_back(x);
            if (x.last) return;
        end
        x.data = rand512(); x.data[31:0] = fid; x.last = (extras == 0);
        b.push_back(x);
        for (int e = 1; e <= extras; e++) begin
            x.data = rand512(); x.last = (e == extras);
            b.push_back(x);
        end
    endfunction

    // Reference model: walk the beat list as the framing rules describe.
    task automatic model_pkt(input beat_t b[$], input int pid);
        logic [31:0] hid;
        logic [1:0]  st;
        int          i;
        bit          done;
        hid = b[0].data[31:0];
        st  = 2'd0;
        if (b[0].last) begin
            st = 2'd1;
        end else begin
            i = 1; done = 0;
            for (int n = 0; n < NBEATS && !done; n++) begin
                exp_tx.push_back('{data: b[i].data, last: b[i].last || (n == NBEATS-1), pid: pid});
                if (b[i].last) begin st = 2'd1; done = 1; end
                i++;
            end
            if (!done) begin
                if (!b[i].last)                  st = 2'd2;
                else if (b[i].data[31:0] != hid) st = 2'd3;
                else                             st = 2'd0;
            end
        end
        exp_cpl.push_back('{id: hid, st: st, pid: pid});
    endtask

    task automatic send_beat(input logic [511:0] d, input logic l);
        bit acc;
        int to;
        if (gap_en && $urandom_range(0, 3) == 0) begin
            AXIS_RX_TVALID = 1'b0;
            @(posedge clk); #1;
        end
        AXIS_RX_TDATA  = d;
        AXIS_RX_TLAST  = l;
        AXIS_RX_TVALID = 1'b1;
        acc = 0; to = 0;
        while (!acc && to < 2000) begin
            @(negedge clk);
            acc = AXIS_RX_TREADY;
            @(posedge clk); #1;
            to++;
        end
        AXIS_RX_TVALID = 1'b0;
        if (!acc) fail_msg("rx_accept_timeout");
    endtask

    task automatic send_pkt(input beat_t b[$]);
        model_pkt(b, next_pid);
        next_pid++;
        foreach (b[k]) send_beat(b[k].data, b[k].last);
    endtask

    task automatic wait_drain(input string name);
        int to = 0;
        while ((exp_tx.size() != 0 || exp_cpl.size() != 0) && to < 5000) begin
            @(posedge clk); #1;
            to++;
        end
        if (exp_tx.size() != 0 || exp_cpl.size() != 0) fail_msg(name);
        @(posedge clk); #1;
        chk({name, "_pkt_count"}, 512'(PKT_COUNT), 512'(cnt_exp(exp_pkt)));
        chk({name, "_err_count"}, 512'(ERR_COUNT), 512'(cnt_exp(exp_err)));
    endtask

    initial begin
        AXIS_TX_TREADY = 1'b1;
        CPL_READY      = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            case (tx_mode)
                0:       AXIS_TX_TREADY = 1'b1;
                1:       AXIS_TX_TREADY = (cyc % 3 == 0);
                default: AXIS_TX_TREADY = 1'($urandom_range(0, 1));
            endcase
            CPL_READY = (tx_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            if (AXIS_TX_TVALID && AXIS_TX_TREADY) begin
                if (exp_tx.size() == 0) begin
                    fail_msg("tx_beat_expected_queue");
                end else begin
                    tx_exp_t t;
                    t = exp_tx.pop_front();
                    chk("tx_data", AXIS_TX_TDATA, t.data);
                    chk("tx_last", 512'(AXIS_TX_TLAST), 512'(t.last));
                end
            end
            if (CPL_VALID && CPL_READY) begin
                if (exp_cpl.size() == 0) begin
                    fail_msg("cpl_expected_queue");
                end else begin
                    cpl_exp_t c;
                    c = exp_cpl.pop_front();
                    chk("cpl_id", 512'(CPL_ID), 512'(c.id));
                    chk("cpl_status", 512'(CPL_STATUS), 512'(c.st));
                    chk("cpl_after_data", 512'(exp_tx.size() != 0 && exp_tx[0].pid <= c.pid), 512'(0));
                    exp_pkt++;
                    if (c.st != 2'd0) exp_err++;
                end
            end
        end
    end

    initial begin
        beat_t b[$];
        resetn         = 1'b0;
        AXIS_RX_TVALID = 1'b0;
        AXIS_RX_TDATA  = '0;
        AXIS_RX_TLAST  = 1'b0;
        #12;
        chk("rst_rx_tready",  512'(AXIS_RX_TREADY), 512'(0));
        chk("rst_tx_tvalid",  512'(AXIS_TX_TVALID), 512'(0));
        chk("rst_tx_tlast",   512'(AXIS_TX_TLAST),  512'(0));
        chk("rst_cpl_valid",  512'(CPL_VALID),      512'(0));
        chk("rst_pkt_count",  512'(PKT_COUNT),      512'(0));
        chk("rst_err_count",  512'(ERR_COUNT),      512'(0));
        @(posedge clk); #1;
        resetn = 1'b1;
        mon_en = 1;
        #1;
        chk("idle_rx_tready", 512'(AXIS_RX_TREADY), 512'(1));

        tx_mode = 0;
        build(32'h1234, 32'h1234, -1, 0, 1, b); send_pkt(b);
        wait_drain("t1_ok");

        tx_mode = 1;
        build(32'h1234, 32'h1234, -1, 0, 1, b); send_pkt(b);
        wait_drain("t2_backpressure");

        tx_mode = 0;
        build(32'h1234, 32'h1234, 5, 0, 1, b); send_pkt(b);
        build(32'h5678, 32'h5678, -1, 0, 0, b); send_pkt(b);
        wait_drain("t3_short");

        build(32'h1234, 32'h1235, -1, 0, 1, b); send_pkt(b);
        wait_drain("t4_mismatch");

        build(32'h1234, 32'h1234, -1, 3, 0, b); send_pkt(b);
        build(32'h9abc, 32'h9abc, -1, 0, 0, b); send_pkt(b);
        wait_drain("t5_long");

        build(32'hcafe, 32'hcafe, 0, 0, 0, b); send_pkt(b);
        build(32'hbeef, 32'hbeef, NBEATS, 0, 0, b); send_pkt(b);
        wait_drain("hdr_tlast_and_last_beat_tlast");

        for (int p = 0; p < 40; p++) begin
            int r;
            logic [31:0] id;
            tx_mode = $urandom_range(0, 2);
            gap_en  = 1'($urandom_range(0, 1));
            id = $urandom;
            r  = $urandom_range(0, 9);
            case (r)
                5, 6:    build(id, id, $urandom_range(0, NBEATS), 0, 0, b);
                7:       build(id, id ^ (32'd1 << $urandom_range(0, 31)), -1, 0, 0, b);
                8:       build(id, id, -1, $urandom_range(1, 4), 0, b);
                default: build(id, id, -1, 0, 0, b);
            endcase
            send_pkt(b);
        end
        wait_drain("random");

        tx_mode = 0;
        gap_en  = 0;
        @(posedge clk); #1;
        mon_en = 0;
        build(32'h1234, 32'h1234, -1, 0, 1, b);
        for (int k = 0; k < 9; k++) send_beat(b[k].data, b[k].last);
        chk("pre_reset_tx_tvalid", 512'(AXIS_TX_TVALID), 512'(1));
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_reset_rx_tready", 512'(AXIS_RX_TREADY), 512'(0));
        chk("mid_reset_tx_tvalid", 512'(AXIS_TX_TVALID), 512'(0));
        chk("mid_reset_tx_tlast",  512'(AXIS_TX_TLAST),  512'(0));
        chk("mid_reset_cpl_valid", 512'(CPL_VALID),      512'(0));
        chk("mid_reset_pkt_count", 512'(PKT_COUNT),      512'(0));
        @(posedge clk); #1;
        resetn = 1'b1;
        exp_tx.delete();
        exp_cpl.delete();
        exp_pkt = 0;
        exp_err = 0;
        mon_en  = 1;
        build(32'h4321, 32'h4321, -1, 0, 1, b); send_pkt(b);
        wait_drain("t6_after_reset");
        chk("t6_one_packet", 512'(exp_pkt), 512'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
